// File: rtl/regfile_param.sv
// Parametrised multi-port register file: two combinational read ports, two
// synchronous write ports, optional hardwired zero register and write bypass.
module regfile_param #(
  parameter int WIDTH    = 32,
  parameter int DEPTH    = 32,
  parameter int ZERO_REG = 1,
  parameter int BYPASS   = 1,
  localparam int AW      = $clog2(DEPTH)
) (
  input  logic             Clk,
  input  logic             Reset_n,
  input  logic [AW-1:0]    ReadRegister1,
  input  logic [AW-1:0]    ReadRegister2,
  output logic [WIDTH-1:0] ReadData1,
  output logic [WIDTH-1:0] ReadData2,
  input  logic [AW-1:0]    WriteRegisterA,
  input  logic [WIDTH-1:0] WriteDataA,
  input  logic             RegWriteA,
  input  logic [AW-1:0]    WriteRegisterB,
  input  logic [WIDTH-1:0] WriteDataB,
  input  logic             RegWriteB
);

  logic [WIDTH-1:0] mem [DEPTH];
  logic             commit_a;
  logic             commit_b;
  logic [AW-1:0]    rd_addr [2];
  logic [WIDTH-1:0] rd_data [2];

  // Writes to the hardwired zero register never reach storage.
  assign commit_a = RegWriteA && !((ZERO_REG != 0) && (WriteRegisterA == '0));
  assign commit_b = RegWriteB && !((ZERO_REG != 0) && (WriteRegisterB == '0));

  // Port B is applied last so it wins an address collision with port A.
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem[i] <= '0;
      end
    end else begin
      if (commit_a) begin
        mem[WriteRegisterA] <= WriteDataA;
      end
      if (commit_b) begin
        mem[WriteRegisterB] <= WriteDataB;
      end
    end
  end

  assign rd_addr[0] = ReadRegister1;
  assign rd_addr[1] = ReadRegister2;

  // Forwarding priority mirrors the collision rule, so a forwarded value is
  // exactly what storage will hold after the edge.
  always_comb begin
    for (int p = 0; p < 2; p++) begin
      rd_data[p] = mem[rd_addr[p]];
      if (BYPASS != 0) begin
        if (RegWriteB && (WriteRegisterB == rd_addr[p])) begin
          rd_data[p] = WriteDataB;
        end else if (RegWriteA && (WriteRegisterA == rd_addr[p])) begin
          rd_data[p] = WriteDataA;
        end
      end
      if ((ZERO_REG != 0) && (rd_addr[p] == '0)) begin
        rd_data[p] = '0;
      end
      if (!Reset_n) begin
        rd_data[p] = '0;
      end
    end
  end

  assign ReadData1 = rd_data[0];
  assign ReadData2 = rd_data[1];

endmodule

// File: tb/tb_regfile_param.sv
// Bench for regfile_param: a 32x32 instance (zero reg, bypass) and a 16x8
// instance (no zero reg, no bypass) checked against array models every cycle.
module tb_regfile_param;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   n_cmp = 0;
  int   n_err = 0;

  always #5 clk = ~clk;

  // Instance A: WIDTH=32 DEPTH=32 ZERO_REG=1 BYPASS=1
  logic [4:0]  a_rr1 = '0, a_rr2 = '0, a_waa = '0, a_wab = '0;
  logic [31:0] a_wda = '0, a_wdb = '0;
  logic        a_wea = 1'b0, a_web = 1'b0;
  logic [31:0] a_rd1, a_rd2;

  // Instance B: WIDTH=16 DEPTH=8 ZERO_REG=0 BYPASS=0
  logic [2:0]  b_rr1 = '0, b_rr2 = '0, b_waa = '0, b_wab = '0;
  logic [15:0] b_wda = '0, b_wdb = '0;
  logic        b_wea = 1'b0, b_web = 1'b0;
  logic [15:0] b_rd1, b_rd2;

  regfile_param #(.WIDTH(32), .DEPTH(32), .ZERO_REG(1), .BYPASS(1)) dut_a (
    .Clk(clk), .Reset_n(rst_n),
    .ReadRegister1(a_rr1), .ReadRegister2(a_rr2),
    .ReadData1(a_rd1), .ReadData2(a_rd2),
    .WriteRegisterA(a_waa), .WriteDataA(a_wda), .RegWriteA(a_wea),
    .WriteRegisterB(a_wab), .WriteDataB(a_wdb), .RegWriteB(a_web)
  );

  regfile_param #(.WIDTH(16), .DEPTH(8), .ZERO_REG(0), .BYPASS(0)) dut_b (
    .Clk(clk), .Reset_n(rst_n),
    .ReadRegister1(b_rr1), .ReadRegister2(b_rr2),
    .ReadData1(b_rd1), .ReadData2(b_rd2),
    .WriteRegisterA(b_waa), .WriteDataA(b_wda), .RegWriteA(b_wea),
    .WriteRegisterB(b_wab), .WriteDataB(b_wdb), .RegWriteB(b_web)
  );

  // ---------------- reference model ----------------
  logic [31:0] ma [32];
  logic [15:0] mb [8];

  initial begin
    for (int i = 0; i < 32; i++) ma[i] = '0;
    for (int i = 0; i < 8; i++)  mb[i] = '0;
  end

  always @(negedge rst_n) begin
    for (int i = 0; i < 32; i++) ma[i] = '0;
    for (int i = 0; i < 8; i++)  mb[i] = '0;
  end

  always @(posedge clk) begin
    if (rst_n) begin
      if (a_wea && a_waa != 5'd0) ma[a_waa] = a_wda;
      if (a_web && a_wab != 5'd0) ma[a_wab] = a_wdb;
      if (b_wea) mb[b_waa] = b_wda;
      if (b_web) mb[b_wab] = b_wdb;
    end
  end

  function automatic logic [31:0] exp_a(input logic [4:0] addr);
    if (!rst_n || addr == 5'd0) return 32'd0;
    if (a_web && a_wab == addr) return a_wdb;
    if (a_wea && a_waa == addr) return a_wda;
    return ma[addr];
  endfunction

  function automatic logic [15:0] exp_b(input logic [2:0] addr);
    if (!rst_n) return 16'd0;
    return mb[addr];
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Continuous comparison against the model, away from the active edge.
  always @(negedge clk) begin
    check("a_rd1", a_rd1, exp_a(a_rr1));
    check("a_rd2", a_rd2, exp_a(a_rr2));
    check("b_rd1", {16'd0, b_rd1}, {16'd0, exp_b(b_rr1)});
    check("b_rd2", {16'd0, b_rd2}, {16'd0, exp_b(b_rr2)});
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_writes();
    a_wea = 1'b0; a_web = 1'b0; b_wea = 1'b0; b_web = 1'b0;
  endtask

  // ---------------- directed + random stimulus ----------------
  initial begin
    #2;
    check("reset_init", a_rd1, 32'd0);
    tick();
    rst_n = 1'b1;

    // Reset clears immediately, without a clock edge.
    a_wea = 1'b1; a_waa = 5'd5; a_wda = 32'hDEADBEEF;
    tick();
    idle_writes();
    a_rr1 = 5'd5; #1;
    check("r5_written", a_rd1, 32'hDEADBEEF);
    rst_n = 1'b0; #1;
    check("reset_async", a_rd1, 32'd0);
    rst_n = 1'b1; #1;
    check("reset_cleared", a_rd1, 32'd0);

    // Write during reset is discarded; first write after release lands.
    tick();
    rst_n = 1'b0; a_wea = 1'b1; a_waa = 5'd6; a_wda = 32'd123;
    tick();
    rst_n = 1'b1; a_wea = 1'b0; a_rr1 = 5'd6; #1;
    check("reset_drops_write", a_rd1, 32'd0);
    a_wea = 1'b1; a_wda = 32'd456;
    tick();
    a_wea = 1'b0; #1;
    check("first_write_after_reset", a_rd1, 32'd456);

    // Dual write, then collision.
    a_wea = 1'b1; a_waa = 5'd3; a_wda = 32'h11111111;
    a_web = 1'b1; a_wab = 5'd7; a_wdb = 32'h22222222;
    tick();
    idle_writes();
    a_rr1 = 5'd3; a_rr2 = 5'd7; #1;
    check("dual_r3_p1", a_rd1, 32'h11111111);
    check("dual_r7_p2", a_rd2, 32'h22222222);
    a_rr1 = 5'd7; a_rr2 = 5'd3; #1;
    check("dual_r7_p1", a_rd1, 32'h22222222);
    check("dual_r3_p2", a_rd2, 32'h11111111);

    a_wea = 1'b1; a_waa = 5'd9; a_wda = 32'hAAAA0000;
    a_web = 1'b1; a_wab = 5'd9; a_wdb = 32'h0000BBBB;
    a_rr1 = 5'd9; #1;
    check("collision_bypass", a_rd1, 32'h0000BBBB);
    tick();
    idle_writes(); #1;
    check("collision_stored", a_rd1, 32'h0000BBBB);

    // Zero register on A; r0 is ordinary on B.
    a_wea = 1'b1; a_waa = 5'd0; a_wda = 32'hFFFFFFFF; a_rr1 = 5'd0;
    b_wea = 1'b1; b_waa = 3'd0; b_wda = 16'hFFFF;     b_rr1 = 3'd0; #1;
    check("zero_write_cycle", a_rd1, 32'd0);
    check("nozero_pre_edge", {16'd0, b_rd1}, 32'h0);
    tick();
    idle_writes(); #1;
    check("zero_after_edge", a_rd1, 32'd0);
    check("nozero_after_edge", {16'd0, b_rd1}, 32'hFFFF);

    // Bypass on A versus stored-only reads on B.
    a_wea = 1'b1; a_waa = 5'd4; a_wda = 32'h1;
    b_wea = 1'b1; b_waa = 3'd4; b_wda = 16'h1;
    tick();
    a_wda = 32'h5; b_wda = 16'h5; a_rr1 = 5'd4; b_rr1 = 3'd4; #1;
    check("bypass_on", a_rd1, 32'h5);
    check("bypass_off", {16'd0, b_rd1}, 32'h1);
    tick();
    idle_writes(); #1;
    check("bypass_off_after", {16'd0, b_rd1}, 32'h5);

    // 16x8 instance: fill every register, read all on both ports.
    for (int n = 0; n < 8; n += 2) begin
      b_wea = 1'b1; b_waa = 3'(n);     b_wda = 16'(n);
      b_web = 1'b1; b_wab = 3'(n + 1); b_wdb = (n + 1 == 7) ? 16'hBEEF : 16'(n + 1);
      tick();
    end
    idle_writes();
    for (int n = 0; n < 8; n++) begin
      b_rr1 = 3'(n); b_rr2 = 3'(n); #1;
      check("fill_p1", {16'd0, b_rd1}, (n == 7) ? 32'hBEEF : 32'(n));
      check("fill_p2", {16'd0, b_rd2}, (n == 7) ? 32'hBEEF : 32'(n));
    end
    tick();

    // Randomized traffic with biased collisions, bypass hits and resets.
    for (int c = 0; c < 600; c++) begin
      rst_n = ($urandom_range(0, 49) != 0);
      a_wea = 1'($urandom_range(0, 1));
      a_web = 1'($urandom_range(0, 1));
      a_waa = ($urandom_range(0, 7) == 0) ? 5'd0 : 5'($urandom_range(0, 31));
      a_wab = ($urandom_range(0, 3) == 0) ? a_waa : 5'($urandom_range(0, 31));
      a_wda = $urandom; a_wdb = $urandom;
      a_rr1 = ($urandom_range(0, 2) == 0) ? a_wab : 5'($urandom_range(0, 31));
      a_rr2 = ($urandom_range(0, 2) == 0) ? a_waa : 5'($urandom_range(0, 31));
      b_wea = 1'($urandom_range(0, 1));
      b_web = 1'($urandom_range(0, 1));
      b_waa = 3'($urandom_range(0, 7));
      b_wab = ($urandom_range(0, 3) == 0) ? b_waa : 3'($urandom_range(0, 7));
      b_wda = 16'($urandom); b_wdb = 16'($urandom);
      b_rr1 = 3'($urandom_range(0, 7));
      b_rr2 = ($urandom_range(0, 2) == 0) ? b_wab : 3'($urandom_range(0, 7));
      tick();
    end
    rst_n = 1'b1;
    idle_writes();
    tick();
    tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
